mealy_seq_detector: RTL and testbench
=====================================

// Module: mealy_seq_detector
// PURPOSE
//  Parametrised Mealy serial-pattern detector; successor to the fixed single-pattern detector.
//  Samples one bit per din_valid cycle; pattern, length and overlap mode are runtime-loaded.
//  z is a combinational Mealy output, asserted in the same cycle as the completing bit.
//  Sits between the pushbutton/serial front end and the LED/display logic.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  LEN_W    4  width of cfg_len / match_len; must hold MAX_LEN
//  CNT_W    8  width of match_count (MATCH_COUNT_EN only)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        synchronous, active-high reset
//  cfg_load     in   1        load cfg_* and (re)arm the detector
//  cfg_pattern  in   MAX_LEN  pattern; bit [cfg_len-1] is received first, bit [0] last
//  cfg_len      in   LEN_W    pattern length; clamped to 2..MAX_LEN on load
//  cfg_overlap  in   1        1 = overlapping matches allowed; 0 = history cleared after a match
//  din_valid    in   1        din is valid this cycle
//  din          in   1        serial data bit (P1)
//  z            out  1        Mealy match: high in the cycle that completes the pattern
//  match_len    out  LEN_W    registered longest pattern prefix currently matched (0..len-1)
//  armed        out  1        detector holds a valid configuration
//  match_count  out  CNT_W    saturating match counter (MATCH_COUNT_EN only)
// BEHAVIOUR
//  Clock/reset: single clk; reset is synchronous, active-high.
//  Reset values: state=S_IDLE, pattern/len/overlap regs=0, history=0, fill=0, match_len=0, armed=0, match_count=0.
//  z is 0 during reset.
//  States:
//   - S_IDLE: z=0; din ignored. cfg_load -> S_RUN.
//   - S_RUN: armed=1. cfg_load -> reload and stay in S_RUN.
//  Load rules:
//   - cfg_load has priority over din_valid in the same cycle; that din is dropped and z=0.
//   - Load clears history, fill and match_len.
//   - cfg_len<2 clamps to 2; cfg_len>MAX_LEN clamps to MAX_LEN.
//  History: shift register of the last MAX_LEN-1 accepted bits, newest at bit 0.
//   - fill counts accepted bits and saturates at MAX_LEN-1.
//  z (combinational) = S_RUN & din_valid & ~cfg_load & fill>=len-1 & {hist,din}[len-1:0]==pattern[len-1:0].
//  On an accepted bit (S_RUN & din_valid & ~cfg_load):
//   - Shift din into history; fill increments.
//   - If z & ~overlap: history and fill clear, match_len<=0.
//   - Otherwise match_len <= largest k<len with the last k bits == pattern[len-1 -: k], limited by fill.
//  din_valid=0: no state change; z=0.
//  Latency: z has 0 cycles from the last pattern bit; match_len updates 1 cycle after the bit.
//  Reset mid-stream: all progress is lost and the detector returns to S_IDLE (must be reloaded).
// CONFIGURATION
//  MATCH_COUNT_EN defined:
//   - match_count port present.
//   - Increments on every z=1 cycle and saturates at 2^CNT_W-1.
//   - Cleared on reset and on cfg_load.
//  MATCH_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package seq_det_pkg holds:
//   - state encoding S_IDLE=1'b0, S_RUN=1'b1;
//   - MIN_LEN=2;
//   - clamp function for cfg_len.
//  Sub-module prefix_tracker (combinational): inputs {hist,din}, pattern, len, fill; outputs full-match and
//  longest-prefix length. The top level holds registers, FSM and the optional counter.
// TESTING
//  1. Pattern 1011, len 4, overlap 1; din 1,0,1,1,1,0,0,1,1,0,1,0 -> z=1 only on the 4th bit;
//     match_len after each bit 1,2,3,1,1,2,0,1,1,2,3,2.
//  2. Pattern 11, len 2: din 1,1,1,1 -> overlap=1: z on bits 2,3,4; overlap=0: z on bits 2,4 only.
//  3. Reset asserted after 3 bits of 1011 -> z=0, armed=0, match_len=0; bits ignored until cfg_load.
//  4. cfg_load together with din_valid=1, din=1 completing a match -> z=0, the bit is dropped, history is cleared.
//  5. cfg_len=0 -> len clamps to 2; cfg_len=15 with MAX_LEN=8 -> len 8; 8-bit pattern A5 detected after exactly 8 bits.
//  6. MATCH_COUNT_EN, CNT_W=2, pattern 11 overlap, six 1s -> count 1,2,3,3,3; cfg_load -> 0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the runtime-configurable serial pattern detector:
// FSM state encoding, minimum pattern length and the cfg_len clamp.
package seq_det_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_LEN = 2;

    // Limit a requested pattern length to MIN_LEN..max_len.
    function automatic int unsigned clamp_len(input int unsigned raw, input int unsigned max_len);
        if (raw < MIN_LEN) begin
            return MIN_LEN;
        end
        if (raw > max_len) begin
            return max_len;
        end
        return raw;
    endfunction

endpackage

// File: rtl/prefix_tracker.sv
// Combinational matcher: full-pattern hit and longest pattern prefix found
// at the tail of the received window {history, din}.
module prefix_tracker
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] window_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [LEN_W-1:0]   fill_i,
    output logic               full_match_o,
    output logic [LEN_W-1:0]   prefix_len_o
);

    localparam logic [MAX_LEN-1:0] ONES = {MAX_LEN{1'b1}};

    int unsigned        len;
    int unsigned        avail;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] k_mask;
    logic [MAX_LEN-1:0] head;
    logic               hit;

    // The window holds fill_i history bits plus the incoming bit.
    always_comb begin
        len          = 32'(len_i);
        avail        = 32'(fill_i) + 32'd1;
        len_mask     = ~(ONES << len);
        full_match_o = (len >= MIN_LEN) && (avail >= len) &&
                       (((window_i ^ pattern_i) & len_mask) == '0);

        // Oldest k pattern bits sit at pattern[len-1 -: k]; align them to bit 0.
        prefix_len_o = '0;
        k_mask       = '0;
        head         = '0;
        hit          = 1'b0;
        for (int unsigned k = 1; k < MAX_LEN; k++) begin
            k_mask = ~(ONES << k);
            head   = (k < len) ? (pattern_i >> (len - k)) : '0;
            hit    = (k < len) && (k <= avail) && (((window_i ^ head) & k_mask) == '0);
            if (hit) begin
                prefix_len_o = LEN_W'(k);
            end
        end
    end

endmodule

// File: rtl/mealy_seq_detector.sv
// Runtime-loadable Mealy serial pattern detector with same-cycle match output.
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module mealy_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    output logic               z,
    output logic [LEN_W-1:0]   match_len,
`ifdef MATCH_COUNT_EN
    output logic               armed,
    output logic [CNT_W-1:0]   match_count
`else
    output logic               armed
`endif
);

    localparam int unsigned HIST_W = MAX_LEN - 1;

    // Reject parameter sets that cannot represent the pattern length.
    if (MAX_LEN < MIN_LEN || (64'd1 << LEN_W) <= 64'(MAX_LEN) || CNT_W < 1) begin : g_bad_params
        $error("mealy_seq_detector: invalid MAX_LEN/LEN_W/CNT_W");
    end

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [HIST_W-1:0]  hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   match_len_q, match_len_d;
    logic               armed_q, armed_d;

    logic [MAX_LEN-1:0] window;
    logic               full_match;
    logic [LEN_W-1:0]   prefix_len;
    logic               accept;

    assign window = {hist_q, din};

    prefix_tracker #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_prefix_tracker (
        .window_i     (window),
        .pattern_i    (pattern_q),
        .len_i        (len_q),
        .fill_i       (fill_q),
        .full_match_o (full_match),
        .prefix_len_o (prefix_len)
    );

    // A load in the same cycle always wins; the coincident bit is dropped.
    assign accept = !reset && (state_q == S_RUN) && din_valid && !cfg_load;
    assign z      = accept && full_match;

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        len_d       = len_q;
        overlap_d   = overlap_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_len_d = match_len_q;
        armed_d     = armed_q;

        if (cfg_load) begin
            state_d     = S_RUN;
            armed_d     = 1'b1;
            pattern_d   = cfg_pattern;
            len_d       = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            overlap_d   = cfg_overlap;
            hist_d      = '0;
            fill_d      = '0;
            match_len_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    armed_d = 1'b0;
                end
                S_RUN: begin
                    if (accept) begin
                        if (z && !overlap_q) begin
                            hist_d      = '0;
                            fill_d      = '0;
                            match_len_d = '0;
                        end else begin
                            hist_d      = window[HIST_W-1:0];
                            fill_d      = (fill_q == LEN_W'(HIST_W)) ? fill_q : fill_q + LEN_W'(1);
                            match_len_d = prefix_len;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    armed_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            hist_q      <= '0;
            fill_q      <= '0;
            match_len_q <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_len_q <= match_len_d;
            armed_q     <= armed_d;
        end
    end

    assign match_len = match_len_q;
    assign armed     = armed_q;

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Saturating count of z pulses since the last load.
    always_comb begin
        count_d = count_q;
        if (cfg_load) begin
            count_d = '0;
        end else if (z && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench for mealy_seq_detector: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_mealy_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
`ifdef MATCH_COUNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 8;
`endif
    localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

    logic               clk;
    logic               reset;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               din_valid;
    logic               din;
    logic               z;
    logic [LEN_W-1:0]   match_len;
    logic               armed;
`ifdef MATCH_COUNT_EN
    logic [TB_CNT_W-1:0] match_count;
`endif

    mealy_seq_detector #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .din_valid   (din_valid),
        .din         (din),
        .z           (z),
        .match_len   (match_len),
`ifdef MATCH_COUNT_EN
        .armed       (armed),
        .match_count (match_count)
`else
        .armed       (armed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: received bits in arrival order, pattern in arrival order.
    int m_armed;
    int m_len;
    int m_ovl;
    int m_ml;
    int m_cnt;
    int pb[MAX_LEN];
    int hist[$];

    int obs_armed;
    int obs_cnt;

    function automatic int model_z();
        int sz;
        if (reset || cfg_load || !din_valid || m_armed == 0) return 0;
        sz = hist.size();
        if (sz < m_len - 1) return 0;
        for (int j = 0; j < m_len - 1; j++)
            if (hist[sz - (m_len - 1) + j] != pb[j]) return 0;
        return (int'(din) == pb[m_len - 1]) ? 1 : 0;
    endfunction

    function automatic int model_ml();
        int sz;
        int ok;
        sz = hist.size();
        for (int k = m_len - 1; k >= 1; k--) begin
            if (k <= sz) begin
                ok = 1;
                for (int j = 0; j < k; j++)
                    if (hist[sz - k + j] != pb[j]) ok = 0;
                if (ok == 1) return k;
            end
        end
        return 0;
    endfunction

    function automatic void model_update(input int ze);
        int l;
        if (reset) begin
            m_armed = 0; m_ml = 0; m_cnt = 0; hist.delete();
            return;
        end
        if (cfg_load) begin
            l = int'(cfg_len);
            m_len = (l < 2) ? 2 : ((l > MAX_LEN) ? MAX_LEN : l);
            for (int j = 0; j < MAX_LEN; j++)
                pb[j] = (j < m_len) ? (int'(cfg_pattern >> (m_len - 1 - j)) & 1) : 0;
            m_armed = 1; m_ovl = int'(cfg_overlap); m_ml = 0; m_cnt = 0; hist.delete();
            return;
        end
        if (m_armed == 1 && din_valid) begin
            if (ze == 1 && m_cnt < CNT_MAX) m_cnt++;
            if (ze == 1 && m_ovl == 0) begin
                hist.delete(); m_ml = 0;
            end else begin
                hist.push_back(int'(din));
                if (hist.size() > MAX_LEN - 1) void'(hist.pop_front());
                m_ml = model_ml();
            end
        end
    endfunction

    // One clock: inputs are already driven at the falling edge on entry.
    task automatic step(output logic zo, output int ze, output int mlo, output int mle);
        #1;
        zo = z;
        ze = model_z();
        @(posedge clk);
        #1;
        mlo = int'(match_len);
        obs_armed = int'(armed);
`ifdef MATCH_COUNT_EN
        obs_cnt = int'(match_count);
`else
        obs_cnt = 0;
`endif
        model_update(ze);
        mle = m_ml;
        @(negedge clk);
    endtask

    task automatic set_in(input logic rst, input logic ld, input logic v, input logic d);
        reset = rst; cfg_load = ld; din_valid = v; din = d;
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
        logic zo; int ze, mlo, mle;
        cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        step(zo, ze, mlo, mle);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic zo; int ze, mlo, mle;
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        step(zo, ze, mlo, mle);
        n_vec++; if (zo !== 1'b0) begin n_err++; $display("FAIL reset_z got %b want 0", zo); end
        n_vec++; if (obs_armed != 0) begin n_err++; $display("FAIL reset_armed got %0d want 0", obs_armed); end
        n_vec++; if (mlo != 0) begin n_err++; $display("FAIL reset_match_len got %0d want 0", mlo); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pattern_1011();
        logic zo; int ze, mlo, mle;
        int bits[12]  = '{1,0,1,1,1,0,0,1,1,0,1,0};
        int exp_ml[12] = '{1,2,3,1,1,2,0,1,1,2,3,2};
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        n_vec++; if (obs_armed != 1) begin n_err++; $display("FAIL p1011_armed got %0d want 1", obs_armed); end
        for (int i = 0; i < 12; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 1'(bits[i]));
            step(zo, ze, mlo, mle);
            n_vec++;
            if (zo !== ((i == 3) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL p1011_z bit%0d got %b want %0d", i + 1, zo, (i == 3) ? 1 : 0);
            end
            n_vec++;
            if (mlo != exp_ml[i]) begin
                n_err++; $display("FAIL p1011_match_len bit%0d got %0d want %0d", i + 1, mlo, exp_ml[i]);
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overlap_11();
        logic zo; int ze, mlo, mle;
        logic want;
        for (int ovl = 1; ovl >= 0; ovl--) begin
            load_cfg(8'b0000_0011, 4'd2, 1'(ovl));
            for (int i = 0; i < 4; i++) begin
                set_in(1'b0, 1'b0, 1'b1, 1'b1);
                step(zo, ze, mlo, mle);
                want = (ovl == 1) ? (i >= 1) : (i == 1 || i == 3);
                n_vec++;
                if (zo !== want) begin
                    n_err++; $display("FAIL ovl11_z ovl%0d bit%0d got %b want %b", ovl, i + 1, zo, want);
                end
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midstream();
        logic zo; int ze, mlo, mle;
        int bits[3] = '{1,0,1};
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 1'(bits[i]));
            step(zo, ze, mlo, mle);
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        step(zo, ze, mlo, mle);
        n_vec++; if (zo !== 1'b0) begin n_err++; $display("FAIL midrst_z got %b want 0", zo); end
        n_vec++; if (obs_armed != 0) begin n_err++; $display("FAIL midrst_armed got %0d want 0", obs_armed); end
        n_vec++; if (mlo != 0) begin n_err++; $display("FAIL midrst_match_len got %0d want 0", mlo); end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 1'(bits[i % 3] | (i == 3 ? 1 : 0)));
            step(zo, ze, mlo, mle);
            n_vec++;
            if (zo !== 1'b0 || mlo != 0) begin
                n_err++; $display("FAIL midrst_idle bit%0d got z=%b ml=%0d want z=0 ml=0", i, zo, mlo);
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load_priority();
        logic zo; int ze, mlo, mle;
        load_cfg(8'b0000_0011, 4'd2, 1'b1);
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        step(zo, ze, mlo, mle);
        set_in(1'b0, 1'b1, 1'b1, 1'b1);
        step(zo, ze, mlo, mle);
        n_vec++; if (zo !== 1'b0) begin n_err++; $display("FAIL loadprio_z got %b want 0", zo); end
        n_vec++; if (mlo != 0) begin n_err++; $display("FAIL loadprio_match_len got %0d want 0", mlo); end
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        step(zo, ze, mlo, mle);
        n_vec++; if (zo !== 1'b0) begin n_err++; $display("FAIL loadprio_hist got z=%b want 0", zo); end
        step(zo, ze, mlo, mle);
        n_vec++; if (zo !== 1'b1) begin n_err++; $display("FAIL loadprio_rematch got z=%b want 1", zo); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_len_clamp();
        logic zo; int ze, mlo, mle;
        logic [7:0] a5 = 8'hA5;
        load_cfg(8'b0000_0011, 4'd0, 1'b1);
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        step(zo, ze, mlo, mle);
        n_vec++; if (zo !== 1'b0) begin n_err++; $display("FAIL clamp_lo_bit1 got z=%b want 0", zo); end
        step(zo, ze, mlo, mle);
        n_vec++; if (zo !== 1'b1) begin n_err++; $display("FAIL clamp_lo_bit2 got z=%b want 1", zo); end
        load_cfg(a5, 4'd15, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            set_in(1'b0, 1'b0, 1'b1, a5[i]);
            step(zo, ze, mlo, mle);
            n_vec++;
            if (zo !== ((i == 0) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL clamp_hi_z bit%0d got %b want %0d", 8 - i, zo, (i == 0) ? 1 : 0);
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef MATCH_COUNT_EN
    task automatic test_match_count();
        logic zo; int ze, mlo, mle;
        int exp_cnt[6] = '{0,1,2,3,3,3};
        load_cfg(8'b0000_0011, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 1'b1);
            step(zo, ze, mlo, mle);
            n_vec++;
            if (obs_cnt != exp_cnt[i]) begin
                n_err++; $display("FAIL count bit%0d got %0d want %0d", i + 1, obs_cnt, exp_cnt[i]);
            end
        end
        load_cfg(8'b0000_0011, 4'd2, 1'b1);
        n_vec++; if (obs_cnt != 0) begin n_err++; $display("FAIL count_clear got %0d want 0", obs_cnt); end
    endtask
`endif

    task automatic test_random();
        logic zo; int ze, mlo, mle;
        int len_pick;
        load_cfg(8'(($urandom)), 4'd3, 1'b1);
        for (int i = 0; i < 600; i++) begin
            cfg_pattern = 8'($urandom);
            len_pick = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 4);
            cfg_len = 4'(len_pick);
            cfg_overlap = 1'($urandom_range(0, 1));
            set_in(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 39) == 0),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            step(zo, ze, mlo, mle);
            n_vec++;
            if (zo !== 1'(ze) || mlo != mle || obs_armed != m_armed) begin
                n_err++;
                $display("FAIL random cyc%0d got z=%b ml=%0d armed=%0d want z=%0d ml=%0d armed=%0d",
                         i, zo, mlo, obs_armed, ze, mle, m_armed);
            end
`ifdef MATCH_COUNT_EN
            n_vec++;
            if (obs_cnt != m_cnt) begin
                n_err++; $display("FAIL random_count cyc%0d got %0d want %0d", i, obs_cnt, m_cnt);
            end
`endif
            if (reset) begin
                set_in(1'b0, 1'b0, 1'b0, 1'b0);
                load_cfg(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        m_armed = 0; m_len = 2; m_ovl = 0; m_ml = 0; m_cnt = 0;
        obs_armed = 0; obs_cnt = 0;
        for (int j = 0; j < MAX_LEN; j++) pb[j] = 0;
        @(negedge clk);
        test_reset();
        test_pattern_1011();
        test_overlap_11();
        test_reset_midstream();
        test_load_priority();
        test_len_clamp();
`ifdef MATCH_COUNT_EN
        test_match_count();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
